// File: rtl/cmd_recorder_pkg.sv
// ---------------------------------------------------------------------------
// cmd_recorder_pkg
//
// Purpose:
//   Shared definitions for the command recorder/player. Holds the playback
//   state type, the default parameter values, the bit positions of the
//   status bus, and a helper that sizes the hold counter.
//
// Contents:
//   state_e           IDLE / RUN playback state
//   DEF_CMD_W         default command word width (left/right torque packed)
//   DEF_DEPTH         default number of stored commands
//   DEF_HOLD_CYCLES   default cycles each command is held during playback
//   STATUS_*          bit index of each flag within the 4-bit status bus
//   timerWidth()      counter width able to count 0..cycles-1
// ---------------------------------------------------------------------------
package cmd_recorder_pkg;

  // The recorder is either editing its store (IDLE) or playing it back (RUN).
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default parameter values used by the top level and the hold timer.
  localparam int DEF_CMD_W       = 18;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_HOLD_CYCLES = 50_000_000;

  // Bit positions inside the status bus {full, empty, busy, err}, which
  // drives LEDG[3:0] directly.
  localparam int STATUS_ERR   = 0;
  localparam int STATUS_BUSY  = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_FULL  = 3;

  // Width of a counter that runs 0..cycles-1. A hold of one cycle still
  // needs a one-bit register so the counter is never zero-width.
  function automatic int timerWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cmd_recorder_hold_timer.sv
// ---------------------------------------------------------------------------
// hold_timer
//
// Purpose:
//   Paces playback. Counts 0..HOLD_CYCLES-1 while enabled and flags the
//   final count with a one-cycle expire, then wraps to 0 so the next entry
//   gets a full hold period with no gap.
//
// Ports:
//   clock_i    system clock, rising edge
//   reset_i    synchronous active-high reset, clears the count
//   start_i    restart the count from 0 (issued when playback begins)
//   enable_i   advance the count this cycle
//   expire_o   high during the last cycle of a hold period
// ---------------------------------------------------------------------------
module hold_timer
  import cmd_recorder_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int TW = timerWidth(HOLD_CYCLES);
  localparam logic [TW-1:0] LAST_COUNT = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] COUNT_ONE  = TW'(1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Expire marks the last cycle of the current hold period. Start has
  // priority over enable so a fresh playback always begins at count 0;
  // an expiring count wraps straight back to 0 for the next entry.
  always_comb begin
    expire_o = enable_i && (count_q == LAST_COUNT);
    count_d  = count_q;
    if (start_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = expire_o ? '0 : (count_q + COUNT_ONE);
    end
  end

  // Plain counter register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cmd_recorder.sv
// ---------------------------------------------------------------------------
// cmd_recorder
//
// Purpose:
//   Records up to DEPTH torque command words from debounced button pulses and
//   plays them back in order, holding each word on cmd_out for HOLD_CYCLES
//   cycles. Sits between the debounce instances and the LEDR/LEDG drivers.
//
// Ports:
//   CLOCK50   system clock, rising edge
//   reset     synchronous active-high reset; clears store, state and outputs
//   save      pulse: append cmd_in to the store (IDLE only)
//   delete    pulse: drop the newest stored word (IDLE only)
//   execute   pulse: start playback from IDLE, or abort a running playback
//   cmd_in    command word captured on save
//   cmd_out   word being played back, 0 when not playing
//   count     number of stored words
//   busy      high while playing
//   err       sticky flag: the last acted-on event was rejected
//   status    {full, empty, busy, err} for LEDG[3:0]
//
// Configuration:
//   CMD_RECORDER_LOOP_EN  when defined, playback wraps from the last entry to
//                         entry 0 with no gap and runs until aborted or reset.
//                         When undefined, one pass is played, then IDLE.
// ---------------------------------------------------------------------------
module cmd_recorder
  import cmd_recorder_pkg::*;
#(
  parameter int CMD_W       = DEF_CMD_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                         CLOCK50,
  input  logic                         reset,
  input  logic                         save,
  input  logic                         delete,
  input  logic                         execute,
  input  logic [CMD_W-1:0]             cmd_in,
  output logic [CMD_W-1:0]             cmd_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         err,
  output logic [3:0]                   status
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             err_q;
  logic             err_d;
  logic             full_q;
  logic             empty_q;
  logic             busy_q;
  logic [CMD_W-1:0] cmd_out_q;
  logic [CMD_W-1:0] mem_q [DEPTH];

  logic execEv;
  logic deleteEv;
  logic saveEv;
  logic startPlay;
  logic memWrite;
  logic lastEntry;
  logic timerEnable;
  logic expire;

  // Coincident pulses resolve as execute > delete > save; the losers are
  // simply dropped rather than queued.
  always_comb begin
    execEv   = execute;
    deleteEv = delete && !execute;
    saveEv   = save && !execute && !delete;
  end

  // Store editing and error flag. Only IDLE reacts to events here: in RUN
  // the count and err hold, and execute is handled as an abort by the FSM.
  // A rejected event (overflow, delete from empty, execute with nothing
  // stored) sets err; any accepted event clears it.
  always_comb begin
    count_d   = count_q;
    err_d     = err_q;
    startPlay = 1'b0;
    memWrite  = 1'b0;
    if (state_q == IDLE) begin
      if (execEv) begin
        if (count_q != '0) begin
          startPlay = 1'b1;
          err_d     = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (deleteEv) begin
        if (count_q != '0) begin
          count_d = count_q - COUNT_ONE;
          err_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else if (saveEv) begin
        if (count_q != COUNT_FULL) begin
          memWrite = 1'b1;
          count_d  = count_q + COUNT_ONE;
          err_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // Playback pacing: the timer only runs in RUN, and the entry being played
  // is the last one when its index reaches count-1.
  always_comb begin
    timerEnable = (state_q == RUN);
    lastEntry   = (CW'(idx_q) == (count_q - COUNT_ONE));
  end

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clock_i  (CLOCK50),
    .reset_i  (reset),
    .start_i  (startPlay),
    .enable_i (timerEnable),
    .expire_o (expire)
  );

  // Command store. Words are appended at index count, so delete only needs
  // to decrement count; stale entries above count are never played. No
  // reset: count=0 masks the contents.
  always_ff @(posedge CLOCK50) begin
    if (!reset && memWrite) begin
      mem_q[count_q[IW-1:0]] <= cmd_in;
    end
  end

  // Playback FSM with its registered outputs. cmd_out and busy are taken
  // from the state and index as they stood before this edge, which puts
  // them one cycle behind the FSM: the first word appears the cycle after
  // execute is accepted, each word is shown for a full hold period, and an
  // abort or the final expiry clears them one cycle later. full/empty are
  // taken from the next count so they track count exactly.
  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      busy_q    <= 1'b0;
      cmd_out_q <= '0;
    end else begin
      count_q   <= count_d;
      err_q     <= err_d;
      full_q    <= (count_d == COUNT_FULL);
      empty_q   <= (count_d == '0);
      busy_q    <= (state_q == RUN);
      cmd_out_q <= (state_q == RUN) ? mem_q[idx_q] : '0;
      case (state_q)
        IDLE: begin
          if (startPlay) begin
            state_q <= RUN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (execEv) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else if (expire) begin
            if (lastEntry) begin
`ifdef CMD_RECORDER_LOOP_EN
              idx_q <= '0;
`else
              state_q <= IDLE;
              idx_q   <= '0;
`endif
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end
        end
      endcase
    end
  end

  // Outputs come straight from registers; status is only a re-packing of
  // the four flag registers into LED order.
  always_comb begin
    cmd_out              = cmd_out_q;
    count                = count_q;
    busy                 = busy_q;
    err                  = err_q;
    status               = '0;
    status[STATUS_FULL]  = full_q;
    status[STATUS_EMPTY] = empty_q;
    status[STATUS_BUSY]  = busy_q;
    status[STATUS_ERR]   = err_q;
  end

endmodule

// File: doc/cmd_recorder.md
# cmd_recorder

Parametrised command recorder/player for the board's button-driven torque control. It captures up to DEPTH command words (packed left/right torque) on debounced `save` pulses and drops the newest on `delete`. On `execute` it plays the stored sequence back, holding each word on the torque output for a fixed number of cycles. It sits between the debounce instances and the LEDR/LEDG drivers, and replaces ad-hoc per-button LED latching with a real store and sequencer.

## Interface
- CMD_W, 18: command word width (left torque in [CMD_W-1:CMD_W/2], right torque in [CMD_W/2-1:0]).
- DEPTH, 16: maximum stored commands; must be ≥ 2.
- HOLD_CYCLES, 50_000_000: cycles each command is driven during playback; must be ≥ 1.

Ports:
- CLOCK50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears store, state and outputs.
- save  in  1  single-cycle pulse: push `cmd_in`.
- delete  in  1  single-cycle pulse: drop newest stored command.
- execute  in  1  single-cycle pulse: start playback, or abort playback if running.
- cmd_in  in  CMD_W  command word sampled on `save`.
- cmd_out  out  CMD_W  torque word being driven; 0 when not playing.
- count  out  $clog2(DEPTH+1)  number of stored commands.
- busy  out  1  high while in RUN.
- err  out  1  sticky: last event was rejected.
- status  out  4  {full, empty, busy, err} for LEDG[3:0].

## Operation
- States: IDLE, RUN.
- Event priority when pulses coincide: execute > delete > save. Only the highest-priority pulse is acted on; the others are discarded.
- IDLE:
  - save: if count < DEPTH, write mem[count] ← cmd_in, count+1, err←0. Else no write, err←1.
  - delete: if count > 0, count−1, err←0. Else err←1.
  - execute: if count > 0, enter RUN with idx=0, cmd_out←mem[0], err←0. Else stay in IDLE, err←1.
- RUN:
  - Each entry is held HOLD_CYCLES cycles, then idx+1 and cmd_out←mem[idx+1].
  - After the last entry (idx = count−1) expires: cmd_out←0, go to IDLE.
  - save and delete are ignored; err is unchanged.
  - execute aborts: cmd_out←0, go to IDLE next cycle; store is retained.
- Store contents persist across playback; only reset, or delete down to 0, empties it.
- full = (count == DEPTH); empty = (count == 0).

## Timing
- Reset values: cmd_out=0, count=0, busy=0, err=0, status=4'b0100, state=IDLE, idx=0, hold counter=0. Memory contents are don't-care; count=0 masks them.
- execute accepted at edge t: busy=1 and cmd_out=mem[0] visible after edge t+1.
- Each entry is visible for exactly HOLD_CYCLES cycles. busy falls and cmd_out=0 after edge t+1+count·HOLD_CYCLES.
- save/delete: count and full/empty update one cycle after the pulse. A save followed by execute on the next cycle plays the new word.
- Abort: cmd_out=0 and busy=0 one cycle after the execute pulse.
- reset wins over every event, including mid-playback. Outputs are reset on the next edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- CMD_RECORDER_LOOP_EN defined: after the last entry, playback wraps to idx=0 with no gap cycle and continues until an execute abort or reset.
- Not defined: single pass, then return to IDLE as described above.

## Structure
- Package cmd_recorder_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - default parameter constants (CMD_W, DEPTH, HOLD_CYCLES);
  - the status bit index constants.
- Sub-module hold_timer counts 0..HOLD_CYCLES−1:
  - inputs: start (clears it), enable;
  - output: a one-cycle `expire` on the final count.
- Memory is a plain register array of DEPTH × CMD_W, written only in IDLE.

## Test plan
Parameters: DEPTH=4, HOLD_CYCLES=4, CMD_W=18.
- Sequence: save 0x00101, 0x00202, 0x00303, then execute → cmd_out = 0x00101, 0x00202, 0x00303, 4 cycles each, then 0; busy high for exactly 12 cycles.
- Fill and overflow: 5 saves → count=4, full=1, err=1 after the 5th save; the 5th word is never played.
- Delete: after 3 saves, delete, then execute → only 2 entries play (8 cycles). Deleting from empty sets err=1 and leaves count=0.
- Abort: execute, then execute again 6 cycles later → cmd_out=0 and busy=0 next cycle; count unchanged; a re-execute plays from mem[0].
- Coincident pulses: execute+save in the same IDLE cycle → playback starts, count unchanged. Reset asserted mid-RUN → all outputs at reset values next cycle, count=0.
- Under CMD_RECORDER_LOOP_EN: 2 entries → cmd_out alternates every 4 cycles for 20+ cycles with no zero gap, until an execute abort.
